// File: rtl/muxnx1_rr_if.sv
// Handshake bundle between N request channels and one registered output beat.
// The master drives requests, selection and downstream accept; the slave (mux) returns accepts and the beat.
interface muxnx1_rr_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 2
);
  logic            mode;
  logic [CW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [CW-1:0]   out_ch;
  logic            out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/muxnx1_rr.sv
// N:1 mux with fixed-select or round-robin arbitration into a single output register.
// One cycle latency, full throughput; in_ready is combinational and only fires when the register can load.
module muxnx1_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 2
) (
  input  logic        clk,
  input  logic        reset,
  muxnx1_rr_if.slave  bus
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [CW-1:0]   out_ch_q,    out_ch_d;
  logic [CW-1:0]   ptr_q,       ptr_d;

  logic            can_load;
  logic            req;
  logic            grant;
  logic [CW-1:0]   cand;
  int              idx;

  always_comb begin
    can_load = !out_valid_q || bus.out_ready;
    req      = 1'b0;
    cand     = '0;
    idx      = 0;
    if (!bus.mode) begin
      if ((int'(bus.sel) < N) && bus.in_valid[bus.sel]) begin
        req  = 1'b1;
        cand = bus.sel;
      end
    end else begin
      // Scan from the far end back toward ptr so the nearest requester is written last.
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (bus.in_valid[idx]) begin
          req  = 1'b1;
          cand = CW'(idx);
        end
      end
    end
    grant = can_load && req && !reset;
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = grant && (cand == CW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(cand)*W +: W];
      out_ch_d    = cand;
      ptr_d       = (cand == CW'(N - 1)) ? '0 : cand + CW'(1);
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_muxnx1_rr.sv
// Bench for muxnx1_rr (N=4, W=8): directed scenarios with literal expectations plus a
// spec-level model compared against the DUT on every falling edge.
module tb_muxnx1_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muxnx1_rr_if #(.N(N), .W(W), .CW(CW)) bus ();

  muxnx1_rr #(.N(N), .W(W), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the beat the output register must be holding and the round-robin start.
  bit       m_vld;
  int       m_data;
  int       m_ch;
  int       m_ptr;

  function automatic int model_grant();
    int c;
    if (reset) return -1;
    if (m_vld && !bus.out_ready) return -1;
    if (!bus.mode) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_vld = 0; m_data = 0; m_ch = 0; m_ptr = 0;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        m_vld  = 1;
        m_data = int'(bus.in_data[g*W +: W]);
        m_ch   = g;
        m_ptr  = (g + 1) % N;
      end else if (!m_vld || bus.out_ready) begin
        m_vld = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    g = model_grant();
    chk("model_in_ready", 64'(bus.in_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("model_out_valid", 64'(bus.out_valid), 64'(m_vld));
    chk("model_out_data", 64'(bus.out_data), 64'(m_data));
    chk("model_out_ch", 64'(bus.out_ch), 64'(m_ch));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic md, input logic [CW-1:0] s, input logic [N-1:0] v, input logic rdy);
    bus.mode      = md;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = rdy;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc(); cyc();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_ch", 64'(bus.out_ch), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 2'd0, 4'b0000, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Fixed select of channel 2.
    cyc();
    bus.in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    drive(1'b0, 2'd2, 4'b0100, 1'b1);
    #1 chk("sel2_in_ready", 64'(bus.in_ready), 64'b0100);
    cyc();
    chk("sel2_out_valid", 64'(bus.out_valid), 64'd1);
    chk("sel2_out_data", 64'(bus.out_data), 64'hA5);
    chk("sel2_out_ch", 64'(bus.out_ch), 64'd2);
    drive(1'b0, 2'd2, 4'b0000, 1'b1);
    cyc();
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_data_hold", 64'(bus.out_data), 64'hA5);

    // Grant channel 3 so the round-robin pointer wraps to 0, then rotate over all four.
    bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    drive(1'b0, 2'd3, 4'b1000, 1'b1);
    cyc();
    chk("sel3_out_ch", 64'(bus.out_ch), 64'd3);
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_out_ch", 64'(bus.out_ch), 64'(k % 4));
      chk("rr_out_data", 64'(bus.out_data), 64'(8'h10 + (k % 4)));
    end

    // Hold the ch0 beat for three cycles under backpressure.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      cyc();
      chk("bp_out_data", 64'(bus.out_data), 64'h10);
      chk("bp_out_ch", 64'(bus.out_ch), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(bus.in_ready), 64'b0010);
    cyc();
    chk("bp_next_ch", 64'(bus.out_ch), 64'd1);

    // Force ptr to 1 via a channel-0 grant, then sparse requests 1001.
    drive(1'b0, 2'd0, 4'b0001, 1'b1);
    cyc();
    drive(1'b1, 2'd0, 4'b1001, 1'b1);
    #1 chk("sparse_rdy3", 64'(bus.in_ready), 64'b1000);
    cyc();
    chk("sparse_ch3", 64'(bus.out_ch), 64'd3);
    #1 chk("sparse_rdy0", 64'(bus.in_ready), 64'b0001);
    cyc();
    chk("sparse_ch0", 64'(bus.out_ch), 64'd0);
    drive(1'b0, 2'd3, 4'b1001, 1'b1);
    #1 chk("mode_flip_rdy", 64'(bus.in_ready), 64'b1000);
    cyc();
    chk("mode_flip_ch", 64'(bus.out_ch), 64'd3);
    chk("mode_flip_data", 64'(bus.out_data), 64'h13);

    // Selected channel idle: no grant, held beat drains.
    drive(1'b0, 2'd3, 4'b0111, 1'b1);
    #1 chk("nosel_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    chk("nosel_out_valid", 64'(bus.out_valid), 64'd0);
    chk("nosel_ch_hold", 64'(bus.out_ch), 64'd3);

    // Async reset pulse while a beat is held.
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    cyc();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_out_ch", 64'(bus.out_ch), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
    chk("post_rst_ch", 64'(bus.out_ch), 64'd0);
    cyc();
    chk("post_rst_ch_next", 64'(bus.out_ch), 64'd1);

    drive(1'b0, 2'd0, 4'b0000, 1'b1);
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
